// File: rtl/esc_throttle_sequencer_pkg.sv
// rtl/esc_throttle_sequencer_pkg.sv - shared state type and duty constants for the ESC throttle path
package esc_throttle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam int DEF_DUTY_W         = 17;
    localparam int DEF_MIN_DUTY       = 12000;
    localparam int DEF_MAX_DUTY       = 21600;
    localparam int DEF_STEP           = 600;
    localparam int DEF_ARM_FRAMES     = 1000;
    localparam int DEF_TIMEOUT_FRAMES = 50;
    // PWM period in 12 MHz counts (500 Hz), shared with the PWM generator
    localparam int PWM_PERIOD         = 24000;

endpackage

// File: rtl/esc_throttle_sequencer_frame_counter.sv
// rtl/esc_throttle_sequencer_frame_counter.sv - frame_tick counter with synchronous clear and terminal flag
module frame_counter #(
    parameter int TERMINAL = 1000,
    parameter int W        = $clog2(TERMINAL + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic term
);

    logic [W-1:0] count;

    // term flags the tick that brings the count up to TERMINAL; clear suppresses it
    assign term = tick & ~clr & (count == W'(TERMINAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/esc_throttle_sequencer.sv
// rtl/esc_throttle_sequencer.sv - ESC arming sequencer, throttle clamp, per-frame slew limit and watchdog
module esc_throttle_sequencer
    import esc_throttle_sequencer_pkg::*;
#(
    parameter int DUTY_W         = DEF_DUTY_W,
    parameter int MIN_DUTY       = DEF_MIN_DUTY,
    parameter int MAX_DUTY       = DEF_MAX_DUTY,
    parameter int STEP           = DEF_STEP,
    parameter int ARM_FRAMES     = DEF_ARM_FRAMES,
    parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              arm_req,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] throttle_cmd,
    output logic [DUTY_W-1:0] duty_out,
    output logic              armed,
    output logic              fault
);

    localparam logic [DUTY_W-1:0]        MIN_D  = DUTY_W'(MIN_DUTY);
    localparam logic [DUTY_W-1:0]        MAX_D  = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0]        STEP_D = DUTY_W'(STEP);
    localparam logic signed [DUTY_W:0]   STEP_S = (DUTY_W + 1)'(STEP);

    state_t                 state;
    logic [DUTY_W-1:0]      target;
    logic [DUTY_W-1:0]      cmd_clamped;
    logic [DUTY_W-1:0]      slewed;
    logic signed [DUTY_W:0] diff;
    logic                   accept;
    logic                   arm_done;
    logic                   wd_expired;

    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        cmd_clamped = throttle_cmd;
        if (throttle_cmd < MIN_D) begin
            cmd_clamped = MIN_D;
        end else if (throttle_cmd > MAX_D) begin
            cmd_clamped = MAX_D;
        end
    end

    // one extra bit keeps the signed distance to target free of wrap
    always_comb begin
        diff   = $signed({1'b0, target}) - $signed({1'b0, duty_out});
        slewed = target;
        if (diff > STEP_S) begin
            slewed = duty_out + STEP_D;
        end else if (diff < -STEP_S) begin
            slewed = duty_out - STEP_D;
        end
    end

    frame_counter #(.TERMINAL(ARM_FRAMES)) u_arm_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != ST_ARM) | ~arm_req),
        .tick  (frame_tick & (state == ST_ARM)),
        .term  (arm_done)
    );

    // an accepted command clears the watchdog even on a tick cycle
    frame_counter #(.TERMINAL(TIMEOUT_FRAMES)) u_wd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != ST_RUN) | accept),
        .tick  (frame_tick & (state == ST_RUN)),
        .term  (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            duty_out  <= '0;
            target    <= MIN_D;
            armed     <= 1'b0;
            fault     <= 1'b0;
            cmd_ready <= 1'b0;
        end else if (!arm_req) begin
            state     <= ST_IDLE;
            duty_out  <= '0;
            armed     <= 1'b0;
            fault     <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_ARM;
                    target   <= MIN_D;
                    duty_out <= '0;
                end
                ST_ARM: begin
                    if (frame_tick) begin
                        duty_out <= MIN_D;
                    end
                    if (arm_done) begin
                        state     <= ST_RUN;
                        armed     <= 1'b1;
                        cmd_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // slew reads the pre-accept target, so a same-cycle command waits a tick
                    if (frame_tick) begin
                        duty_out <= slewed;
                    end
                    if (accept) begin
                        target <= cmd_clamped;
                    end
                    if (wd_expired) begin
                        state     <= ST_FAULT;
                        armed     <= 1'b0;
                        cmd_ready <= 1'b0;
                        fault     <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (frame_tick) begin
                        duty_out <= MIN_D;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esc_throttle_sequencer.sv
// tb/tb_esc_throttle_sequencer.sv - self-checking bench for esc_throttle_sequencer
module tb_esc_throttle_sequencer;

    localparam int MIN_V   = 12000;
    localparam int MAX_V   = 21600;
    localparam int STEP_V  = 600;
    localparam int ARM_N   = 1000;
    localparam int TMO_N   = 50;

    localparam int S_IDLE  = 0;
    localparam int S_ARM   = 1;
    localparam int S_RUN   = 2;
    localparam int S_FAULT = 3;

    typedef struct {
        int st;
        int duty;
        int tgt;
        int acnt;
        int wd;
    } model_t;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        arm_req;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [16:0] throttle_cmd;
    logic [16:0] duty_out;
    logic        armed;
    logic        fault;

    int     checks = 0;
    int     errors = 0;
    bit     cmp_en = 0;
    model_t m;

    esc_throttle_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .arm_req      (arm_req),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .throttle_cmd (throttle_cmd),
        .duty_out     (duty_out),
        .armed        (armed),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_cmd(int v);
        if (v < MIN_V) return MIN_V;
        if (v > MAX_V) return MAX_V;
        return v;
    endfunction

    function automatic int approach(int d, int t);
        if (t - d > STEP_V) return d + STEP_V;
        if (d - t > STEP_V) return d - STEP_V;
        return t;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.st = S_IDLE; r.duty = 0; r.tgt = MIN_V; r.acnt = 0; r.wd = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, logic arm, logic tick, logic valid, int cmd);
        model_t n = c;
        if (!arm) begin
            n.st = S_IDLE;
            n.duty = 0;
        end else begin
            case (c.st)
                S_IDLE: begin
                    n.st = S_ARM; n.acnt = 0; n.tgt = MIN_V;
                end
                S_ARM: if (tick) begin
                    n.duty = MIN_V;
                    n.acnt = c.acnt + 1;
                    if (n.acnt == ARM_N) begin
                        n.st = S_RUN; n.wd = 0;
                    end
                end
                S_RUN: begin
                    if (tick) n.duty = approach(c.duty, c.tgt);
                    if (valid) begin
                        n.tgt = clamp_cmd(cmd);
                        n.wd = 0;
                    end else if (tick) begin
                        n.wd = c.wd + 1;
                        if (n.wd == TMO_N) n.st = S_FAULT;
                    end
                end
                default: if (tick) n.duty = MIN_V;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, arm_req, frame_tick, cmd_valid, int'(throttle_cmd));
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_duty",  int'(duty_out),  m.duty);
            chk("model_armed", int'(armed),     int'(m.st == S_RUN));
            chk("model_fault", int'(fault),     int'(m.st == S_FAULT));
            chk("model_ready", int'(cmd_ready), int'(m.st == S_RUN));
        end
    end

    task automatic do_tick();
        @(posedge clk); #2 frame_tick = 1'b1;
        @(posedge clk); #2 frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic send_cmd(input int v);
        @(posedge clk); #2 cmd_valid = 1'b1; throttle_cmd = 17'(v);
        @(posedge clk); #2 cmd_valid = 1'b0;
    endtask

    task automatic arm_sequence();
        arm_req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("arm_duty_pre_tick", int'(duty_out), 0);
        chk("arm_ready_low", int'(cmd_ready), 0);
        do_tick();
        chk("arm_duty_first_tick", int'(duty_out), MIN_V);
        ticks(ARM_N - 2);
        chk("arm_not_yet", int'(armed), 0);
        chk("arm_ready_still_low", int'(cmd_ready), 0);
        do_tick();
        chk("armed_at_1000", int'(armed), 1);
        chk("ready_in_run", int'(cmd_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; arm_req = 1'b0;
        cmd_valid = 1'b0; throttle_cmd = '0;
        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        chk("reset_duty", int'(duty_out), 0);
        chk("reset_armed", int'(armed), 0);
        chk("reset_fault", int'(fault), 0);
        chk("reset_ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        arm_sequence();

        send_cmd(21600);
        for (int i = 1; i <= 16; i++) begin
            do_tick();
            chk("slew_up", int'(duty_out), (MIN_V + STEP_V * i > MAX_V) ? MAX_V : MIN_V + STEP_V * i);
        end
        do_tick();
        chk("slew_up_stable", int'(duty_out), 21600);

        send_cmd(20000);
        do_tick(); chk("slew_dn_1", int'(duty_out), 21000);
        do_tick(); chk("slew_dn_2", int'(duty_out), 20400);
        do_tick(); chk("slew_dn_3", int'(duty_out), 20000);
        do_tick(); chk("slew_dn_hold", int'(duty_out), 20000);

        send_cmd(5000);
        ticks(13);
        chk("clamp_low_13", int'(duty_out), 12200);
        do_tick(); chk("clamp_low_14", int'(duty_out), 12000);
        do_tick(); chk("clamp_low_hold", int'(duty_out), 12000);

        send_cmd(30000);
        ticks(15);
        chk("clamp_high_15", int'(duty_out), 21000);
        do_tick(); chk("clamp_high_16", int'(duty_out), 21600);
        do_tick(); chk("clamp_high_hold", int'(duty_out), 21600);

        @(posedge clk); #2 frame_tick = 1'b1; cmd_valid = 1'b1; throttle_cmd = 17'd15000;
        @(posedge clk); #2 frame_tick = 1'b0; cmd_valid = 1'b0;
        chk("simul_old_target", int'(duty_out), 21600);
        repeat (3) @(posedge clk);
        #2;
        do_tick(); chk("simul_new_target", int'(duty_out), 21000);

        ticks(48);
        chk("wd_49_no_fault", int'(fault), 0);
        chk("wd_49_duty", int'(duty_out), 15000);
        do_tick();
        chk("wd_50_fault", int'(fault), 1);
        chk("wd_50_armed", int'(armed), 0);
        chk("wd_50_ready", int'(cmd_ready), 0);
        chk("wd_50_duty_wait", int'(duty_out), 15000);
        do_tick(); chk("fault_duty_min", int'(duty_out), MIN_V);
        send_cmd(20000);
        do_tick(); chk("fault_cmd_ignored", int'(duty_out), MIN_V);
        chk("fault_sticky", int'(fault), 1);
        arm_req = 1'b0;
        @(posedge clk); #2;
        chk("fault_exit_duty", int'(duty_out), 0);
        chk("fault_exit_flag", int'(fault), 0);

        arm_sequence();
        send_cmd(18000);
        ticks(10);
        chk("rearm_duty", int'(duty_out), 18000);
        @(posedge clk); #2 arm_req = 1'b0;
        @(posedge clk); #2;
        chk("disarm_duty", int'(duty_out), 0);
        chk("disarm_armed", int'(armed), 0);

        arm_sequence();
        send_cmd(21600);
        ticks(3);
        chk("preresets_duty", int'(duty_out), 13800);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_duty", int'(duty_out), 0);
        chk("async_rst_armed", int'(armed), 0);
        chk("async_rst_ready", int'(cmd_ready), 0);
        chk("async_rst_fault", int'(fault), 0);
        repeat (2) @(posedge clk);
        #2;
        arm_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
